// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared sizing helpers for the FIFO controller
package fifo_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int depth);
        return depth + 1;
    endfunction

    function automatic int capacity(input int depth);
        return 1 << depth;
    endfunction

    function automatic int af_level_default(input int depth);
        return (1 << depth) - 2;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping FIFO pointer with increment and synchronous clear
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - first-word-fall-through FIFO controller for an external register-file RAM
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = af_level_default(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ram_wr_en,
    output logic [DEPTH-1:0] ram_wr_addr,
    output logic [WIDTH-1:0] ram_wr_data,
    output logic [DEPTH-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0] ram_rd_data,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push, pop;

    assign full  = (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]) && (wr_ptr[DEPTH] != rd_ptr[DEPTH]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // Flush wins over any handshake in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr[DEPTH-1:0];
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr[DEPTH-1:0];
    assign out_data    = ram_rd_data;

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + PW'(1);
            end else if (pop && !push) begin
                count_d = count_q - PW'(1);
            end
            if (in_valid && full) begin
                overflow_d = 1'b1;
            end
            if (out_ready && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count       = count_q;
    assign almost_full = (count_q >= AF_THR);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
